// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and uart-side transmit signals shared by uart_tx_arbiter.
// master = client/uart environment, slave = the arbiter.
interface uart_tx_arbiter_if #(
   parameter int unsigned N_REQ = 4
);
   logic [N_REQ-1:0]   req_valid;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   req_last;
   logic [N_REQ-1:0]   req_ready;
   logic [N_REQ-1:0]   grant;
   logic               busy;
   logic [7:0]         w_data;
   logic               wr_uart;
   logic               tx_full;

   modport master (
      output req_valid, req_data, req_last, tx_full,
      input  req_ready, grant, busy, w_data, wr_uart
   );

   modport slave (
      input  req_valid, req_data, req_last, tx_full,
      output req_ready, grant, busy, w_data, wr_uart
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter for the shared uart transmit port.
// Optional source-tag header byte per grant: define UART_TX_ARB_SRC_TAG_EN.
module uart_tx_arbiter #(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned MAX_BURST = 16
) (
   input logic                   clk,
   input logic                   reset_n,
   uart_tx_arbiter_if.slave      bus
);
   localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

`ifdef UART_TX_ARB_SRC_TAG_EN
   typedef enum logic [1:0] {IDLE, TAG, XFER} state_t;
`else
   typedef enum logic [1:0] {IDLE, XFER} state_t;
`endif

   state_t           state_q;
   logic [N_REQ-1:0] grant_q;
   logic [IW-1:0]    owner_q;
   logic [IW-1:0]    rr_ptr_q;
   logic [7:0]       burst_cnt_q;

   logic [IW-1:0]    pick;
   logic [N_REQ-1:0] pick_oh;
   logic             pick_found;
   logic [IW-1:0]    rr_next;
   logic             wr;
   logic [7:0]       w_data_c;
   logic [N_REQ-1:0] ready_c;
   logic             end_of_grant;

   // Search rr_ptr, rr_ptr+1, ... wrapping at N_REQ; first valid wins.
   always_comb begin
      int unsigned idx;
      idx        = 0;
      pick       = '0;
      pick_oh    = '0;
      pick_found = 1'b0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = 32'(rr_ptr_q) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!pick_found && bus.req_valid[IW'(idx)]) begin
            pick_found          = 1'b1;
            pick                = IW'(idx);
            pick_oh[IW'(idx)]   = 1'b1;
         end
      end
   end

   assign rr_next = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);

   always_comb begin
      ready_c  = '0;
      wr       = 1'b0;
      w_data_c = '0;
      case (state_q)
`ifdef UART_TX_ARB_SRC_TAG_EN
         TAG: begin
            wr = !bus.tx_full;
            if (wr) w_data_c = {4'hA, 4'(owner_q)};
         end
`endif
         XFER: begin
            ready_c[owner_q] = !bus.tx_full;
            wr = bus.req_valid[owner_q] && !bus.tx_full;
            if (wr) w_data_c = bus.req_data[{owner_q, 3'b000} +: 8];
         end
         default: ;
      endcase
   end

   assign end_of_grant = bus.req_last[owner_q] || (burst_cnt_q == 8'(MAX_BURST - 1));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_found) begin
                  grant_q <= pick_oh;
                  owner_q <= pick;
`ifdef UART_TX_ARB_SRC_TAG_EN
                  state_q <= TAG;
`else
                  state_q <= XFER;
`endif
               end
            end
`ifdef UART_TX_ARB_SRC_TAG_EN
            TAG: begin
               if (wr) state_q <= XFER;
            end
`endif
            XFER: begin
               if (wr) begin
                  if (end_of_grant) begin
                     rr_ptr_q    <= rr_next;
                     grant_q     <= '0;
                     burst_cnt_q <= '0;
                     state_q     <= IDLE;
                  end else begin
                     burst_cnt_q <= burst_cnt_q + 8'd1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = ready_c;
   assign bus.wr_uart   = wr;
   assign bus.w_data    = w_data_c;
   assign bus.grant     = grant_q;
   assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed table-driven bench for uart_tx_arbiter (N_REQ=4, MAX_BURST=16).
module tb_uart_tx_arbiter;
   logic clk;
   logic reset_n;
   int   nvec;
   int   nfail;

   uart_tx_arbiter_if #(.N_REQ(4)) bus ();

   uart_tx_arbiter #(.N_REQ(4), .MAX_BURST(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic [3:0]  valid;
      logic [31:0] data;
      logic [3:0]  last;
      logic        full;
      logic [3:0]  e_grant;
      logic [3:0]  e_ready;
      logic        e_wr;
      logic [7:0]  e_wdata;
      logic        e_busy;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic [3:0] v, input logic [31:0] d,
                        input logic [3:0] l, input logic f);
      reset_n       = r;
      bus.req_valid = v;
      bus.req_data  = d;
      bus.req_last  = l;
      bus.tx_full   = f;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] r,
                          input logic w, input logic [7:0] wd, input logic b);
      chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
      chk({tag, ".ready"}, 32'(bus.req_ready), 32'(r));
      chk({tag, ".wr"}, 32'(bus.wr_uart), 32'(w));
      chk({tag, ".wdata"}, 32'(bus.w_data), 32'(wd));
      chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
      chk({tag, ".onehot0"}, 32'($onehot0(bus.grant)), 32'd1);
      chk({tag, ".nowr_full"}, 32'(bus.wr_uart & bus.tx_full), 32'd0);
   endtask

   task automatic do_reset();
      tick(); drive(1'b0, 4'hF, 32'h0, 4'h0, 1'b0);
      tick();
      tick(); drive(1'b1, 4'h0, 32'h0, 4'h0, 1'b0);
   endtask

   task automatic add(input logic r, input logic [3:0] v, input logic [31:0] d,
                      input logic [3:0] l, input logic f, input logic [3:0] g,
                      input logic [3:0] rd, input logic w, input logic [7:0] wd,
                      input logic b);
      vec_t t;
      t = '{r, v, d, l, f, g, rd, w, wd, b};
      tbl.push_back(t);
   endtask

   initial begin
      nvec  = 0;
      nfail = 0;
      drive(1'b0, 4'hF, 32'hA5A5A5A5, 4'h0, 1'b0);

`ifndef UART_TX_ARB_SRC_TAG_EN
      // reset with all valids high
      add(0, 4'hF, 32'hA5A5A5A5, 4'h0, 0, 4'h0, 4'h0, 0, 8'h00, 0);
      add(0, 4'hF, 32'hA5A5A5A5, 4'h0, 0, 4'h0, 4'h0, 0, 8'h00, 0);
      // req0: 0x11,0x22,0x33
      add(1, 4'h1, 32'h11, 4'h0, 0, 4'h0, 4'h0, 0, 8'h00, 0);
      add(1, 4'h1, 32'h11, 4'h0, 0, 4'h1, 4'h1, 1, 8'h11, 1);
      add(1, 4'h1, 32'h22, 4'h0, 0, 4'h1, 4'h1, 1, 8'h22, 1);
      add(1, 4'h1, 32'h33, 4'h1, 0, 4'h1, 4'h1, 1, 8'h33, 1);
      add(1, 4'h0, 32'h00, 4'h0, 0, 4'h0, 4'h0, 0, 8'h00, 0);
      // reset rr_ptr, then all four with 1-byte packets
      add(0, 4'h0, 32'h00, 4'h0, 0, 4'h0, 4'h0, 0, 8'h00, 0);
      add(1, 4'hF, 32'h0D0C0B0A, 4'hF, 0, 4'h0, 4'h0, 0, 8'h00, 0);
      add(1, 4'hF, 32'h0D0C0B0A, 4'hF, 0, 4'h1, 4'h1, 1, 8'h0A, 1);
      add(1, 4'hF, 32'h0D0C0B0A, 4'hF, 0, 4'h0, 4'h0, 0, 8'h00, 0);
      add(1, 4'hF, 32'h0D0C0B0A, 4'hF, 0, 4'h2, 4'h2, 1, 8'h0B, 1);
      add(1, 4'hF, 32'h0D0C0B0A, 4'hF, 0, 4'h0, 4'h0, 0, 8'h00, 0);
      add(1, 4'hF, 32'h0D0C0B0A, 4'hF, 0, 4'h4, 4'h4, 1, 8'h0C, 1);
      add(1, 4'hF, 32'h0D0C0B0A, 4'hF, 0, 4'h0, 4'h0, 0, 8'h00, 0);
      add(1, 4'hF, 32'h0D0C0B0A, 4'hF, 0, 4'h8, 4'h8, 1, 8'h0D, 1);
      add(1, 4'hF, 32'h0D0C0B0A, 4'hF, 0, 4'h0, 4'h0, 0, 8'h00, 0);
      add(1, 4'hF, 32'h0D0C0B0A, 4'hF, 0, 4'h1, 4'h1, 1, 8'h0A, 1);
      add(1, 4'h0, 32'h00, 4'h0, 0, 4'h0, 4'h0, 0, 8'h00, 0);
      // req1 2-byte packet with 5-cycle tx_full stall after first byte
      add(1, 4'h2, 32'h4100, 4'h0, 0, 4'h0, 4'h0, 0, 8'h00, 0);
      add(1, 4'h2, 32'h4100, 4'h0, 0, 4'h2, 4'h2, 1, 8'h41, 1);
      for (int i = 0; i < 5; i++)
         add(1, 4'h2, 32'h4200, 4'h2, 1, 4'h2, 4'h0, 0, 8'h00, 1);
      add(1, 4'h2, 32'h4200, 4'h2, 0, 4'h2, 4'h2, 1, 8'h42, 1);
      add(1, 4'h0, 32'h00, 4'h0, 0, 4'h0, 4'h0, 0, 8'h00, 0);

      foreach (tbl[i]) begin
         tick();
         drive(tbl[i].rst_n, tbl[i].valid, tbl[i].data, tbl[i].last, tbl[i].full);
         @(negedge clk);
         chk_out($sformatf("v%0d", i), tbl[i].e_grant, tbl[i].e_ready, tbl[i].e_wr,
                 tbl[i].e_wdata, tbl[i].e_busy);
      end

      // burst cap: req1 streams 20 bytes without last, req2 sends 1-byte packets
      do_reset();
      @(negedge clk);
      chk_out("cap.rst", 4'h0, 4'h0, 0, 8'h00, 0);
      tick(); drive(1'b1, 4'h6, 32'h00770000, 4'h4, 1'b0);
      @(negedge clk);
      chk_out("cap.idle0", 4'h0, 4'h0, 0, 8'h00, 0);
      for (int k = 0; k < 16; k++) begin
         tick(); bus.req_data[15:8] = 8'(k);
         @(negedge clk);
         chk_out($sformatf("cap.b%0d", k), 4'h2, 4'h2, 1, 8'(k), 1);
      end
      tick(); bus.req_data[15:8] = 8'd16;
      @(negedge clk);
      chk_out("cap.bubble", 4'h0, 4'h0, 0, 8'h00, 0);
      tick();
      @(negedge clk);
      chk_out("cap.req2", 4'h4, 4'h4, 1, 8'h77, 1);
      tick();
      @(negedge clk);
      chk_out("cap.idle1", 4'h0, 4'h0, 0, 8'h00, 0);
      for (int k = 16; k < 20; k++) begin
         tick(); bus.req_data[15:8] = 8'(k);
         @(negedge clk);
         chk_out($sformatf("cap.b%0d", k), 4'h2, 4'h2, 1, 8'(k), 1);
      end
      // owner drops valid: grant held, nothing written
      for (int k = 0; k < 3; k++) begin
         tick(); bus.req_valid = 4'h4;
         @(negedge clk);
         chk_out($sformatf("cap.hold%0d", k), 4'h2, 4'h2, 0, 8'h00, 1);
      end
      // reset mid-packet aborts
      tick(); reset_n = 1'b0;
      tick(); bus.req_valid = 4'h6;
      @(negedge clk);
      chk_out("cap.abort", 4'h0, 4'h0, 0, 8'h00, 0);
`else
      // header byte precedes the payload byte
      do_reset();
      @(negedge clk);
      chk_out("tag.rst", 4'h0, 4'h0, 0, 8'h00, 0);
      tick(); drive(1'b1, 4'h4, 32'h005A0000, 4'h4, 1'b1);
      @(negedge clk);
      chk_out("tag.idle", 4'h0, 4'h0, 0, 8'h00, 0);
      tick();
      @(negedge clk);
      chk_out("tag.stall", 4'h4, 4'h0, 0, 8'h00, 1);
      tick(); bus.tx_full = 1'b0;
      @(negedge clk);
      chk_out("tag.hdr", 4'h4, 4'h0, 1, 8'hA2, 1);
      tick();
      @(negedge clk);
      chk_out("tag.data", 4'h4, 4'h4, 1, 8'h5A, 1);
      tick(); bus.req_valid = 4'h0;
      @(negedge clk);
      chk_out("tag.done", 4'h0, 4'h0, 0, 8'h00, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
